bist_scan_controller: RTL

- Sequencing FSM for the per-scan BIST datapath; sits in the top-level BIST wrapper beside the pattern generator (LFSR), the response compactor (MISR) and the CUT input mux.
- On bist_start it seeds the LFSR and clears the MISR, then runs N_PATTERNS shift/capture rounds and a final unload.
- After the unload it compares the MISR signature against a golden value and reports bist_end and pass_nfail.

---
 rtl/bist_pkg.sv | 25 ++
 rtl/bist_scan_controller_if.sv | 41 ++++
 rtl/bist_terminal_counter.sv | 31 +++
 rtl/bist_scan_controller.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/bist_pkg.sv
// Shared definitions for the BIST scan controller.
//   - bist_state_e     : 3-bit FSM state encoding (IDLE..DONE, code 7 is illegal)
//   - DefaultSigWidth  : default MISR signature width
//   - cycles_to_done() : cycles from INIT entry to DONE entry for a given config
package bist_pkg;

  localparam int unsigned DefaultSigWidth = 16;

  typedef enum logic [2:0] {
    StIdle    = 3'd0,
    StInit    = 3'd1,
    StShift   = 3'd2,
    StCapture = 3'd3,
    StUnload  = 3'd4,
    StCompare = 3'd5,
    StDone    = 3'd6
  } bist_state_e;

  // INIT + N x (SHIFT + CAPTURE) + UNLOAD + COMPARE
  function automatic int unsigned cycles_to_done(input int unsigned scan_len,
                                                 input int unsigned n_patterns);
    return 1 + n_patterns * (scan_len + 1) + scan_len + 1;
  endfunction

endpackage

// File: rtl/bist_scan_controller_if.sv
// Control/status bundle between the BIST wrapper and the scan controller.
//   master : drives bist_start, misr_sig (and bist_abort); observes all controls/status
//   slave  : the controller; drives bist_mode, tpg_init, tpg_en, misr_init, misr_en,
//            scan_en, busy, bist_end, pass_nfail
// Optional: `define BIST_ABORT_EN adds the bist_abort request.
interface bist_scan_controller_if #(
  parameter int unsigned SIG_WIDTH = bist_pkg::DefaultSigWidth
);
  logic                 bist_start;
  logic [SIG_WIDTH-1:0] misr_sig;
`ifdef BIST_ABORT_EN
  logic                 bist_abort;
`endif
  logic                 bist_mode;
  logic                 tpg_init;
  logic                 tpg_en;
  logic                 misr_init;
  logic                 misr_en;
  logic                 scan_en;
  logic                 busy;
  logic                 bist_end;
  logic                 pass_nfail;

  modport master (
`ifdef BIST_ABORT_EN
    output bist_abort,
`endif
    output bist_start, misr_sig,
    input  bist_mode, tpg_init, tpg_en, misr_init, misr_en, scan_en, busy, bist_end,
           pass_nfail
  );

  modport slave (
`ifdef BIST_ABORT_EN
    input  bist_abort,
`endif
    input  bist_start, misr_sig,
    output bist_mode, tpg_init, tpg_en, misr_init, misr_en, scan_en, busy, bist_end,
           pass_nfail
  );
endinterface

// File: rtl/bist_terminal_counter.sv
// Up-counter with synchronous clear and a terminal-value flag.
//   i_clock  : clock, rising edge
//   i_reset  : synchronous active-high reset
//   i_clr    : clear to zero (wins over i_en)
//   i_en     : count up by one
//   o_at_max : counter currently equals MAX
// The owning FSM leaves the counting state or clears at MAX, so it never wraps.
module bist_terminal_counter #(
  parameter int unsigned MAX   = 1,
  parameter int unsigned WIDTH = 1
) (
  input  logic i_clock,
  input  logic i_reset,
  input  logic i_clr,
  input  logic i_en,
  output logic o_at_max
);

  logic [WIDTH-1:0] r_cnt;

  always_ff @(posedge i_clock) begin
    if (i_reset || i_clr) begin
      r_cnt <= '0;
    end else if (i_en) begin
      r_cnt <= r_cnt + WIDTH'(1);
    end
  end

  assign o_at_max = (r_cnt == WIDTH'(MAX));

endmodule

// File: rtl/bist_scan_controller.sv
// Sequencing FSM for the per-scan BIST datapath (LFSR, MISR, CUT input mux).
//   i_clock : system clock, rising edge
//   i_reset : synchronous active-high reset, aborts any run without a result
//   io_bist : slave side of bist_scan_controller_if
//             in : bist_start (level), misr_sig, bist_abort (optional)
//             out: bist_mode, tpg_init, tpg_en, misr_init, misr_en, scan_en,
//                  busy, bist_end, pass_nfail
// Sequence: IDLE -> INIT -> (SHIFT x SCAN_LEN, CAPTURE) x N_PATTERNS
//           -> UNLOAD x SCAN_LEN -> COMPARE -> DONE.
// Optional: `define BIST_ABORT_EN to let bist_abort force DONE (fail) from any busy state.
module bist_scan_controller
  import bist_pkg::*;
#(
  parameter int unsigned          SCAN_LEN   = 8,
  parameter int unsigned          N_PATTERNS = 256,
  parameter int unsigned          SIG_WIDTH  = DefaultSigWidth,
  parameter logic [SIG_WIDTH-1:0] GOLDEN_SIG = '0
) (
  input  logic                   i_clock,
  input  logic                   i_reset,
  bist_scan_controller_if.slave  io_bist
);

  localparam int unsigned ShiftW = (SCAN_LEN > 1) ? $clog2(SCAN_LEN) : 1;
  localparam int unsigned PatW   = $clog2(N_PATTERNS + 1);

  bist_state_e r_state;
  bist_state_e w_state_next;

  logic w_shift_last;
  logic w_pat_last;
  logic w_shift_en;
  logic w_shift_clr;
  logic w_abort;
  logic w_busy;
  logic r_first;   // first pattern in flight: chain holds no response yet
  logic r_pass;

  logic w_bist_mode;
  logic w_tpg_init;
  logic w_tpg_en;
  logic w_misr_init;
  logic w_misr_en;
  logic w_scan_en;
  logic w_bist_end;

  assign w_busy = (r_state != StIdle) && (r_state != StDone);

`ifdef BIST_ABORT_EN
  assign w_abort = io_bist.bist_abort && w_busy;
`else
  assign w_abort = 1'b0;
`endif

  // Shift counter is shared by SHIFT and UNLOAD; both last SCAN_LEN cycles.
  assign w_shift_en  = (r_state == StShift) || (r_state == StUnload);
  assign w_shift_clr = (r_state == StInit) || (w_shift_en && w_shift_last);

  bist_terminal_counter #(
    .MAX   (SCAN_LEN - 1),
    .WIDTH (ShiftW)
  ) u_shift_cnt (
    .i_clock  (i_clock),
    .i_reset  (i_reset),
    .i_clr    (w_shift_clr),
    .i_en     (w_shift_en),
    .o_at_max (w_shift_last)
  );

  // at_max flags the final pattern being captured; the count then reaches N_PATTERNS.
  bist_terminal_counter #(
    .MAX   (N_PATTERNS - 1),
    .WIDTH (PatW)
  ) u_pat_cnt (
    .i_clock  (i_clock),
    .i_reset  (i_reset),
    .i_clr    (r_state == StInit),
    .i_en     (r_state == StCapture),
    .o_at_max (w_pat_last)
  );

  // State register
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      StIdle:    if (io_bist.bist_start) w_state_next = StInit;
      StInit:    w_state_next = StShift;
      StShift:   if (w_shift_last) w_state_next = StCapture;
      StCapture: w_state_next = w_pat_last ? StUnload : StShift;
      StUnload:  if (w_shift_last) w_state_next = StCompare;
      StCompare: w_state_next = StDone;
      StDone:    if (!io_bist.bist_start) w_state_next = StIdle;
      default:   w_state_next = StIdle;
    endcase
    if (w_abort) begin
      w_state_next = StDone;
    end
  end

  // First-pattern flag and registered verdict
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_first <= 1'b0;
      r_pass  <= 1'b0;
    end else begin
      if (r_state == StInit) begin
        r_first <= 1'b1;
      end else if (r_state == StCapture) begin
        r_first <= 1'b0;
      end

      if (w_abort || (r_state == StInit)) begin
        r_pass <= 1'b0;
      end else if (r_state == StCompare) begin
        r_pass <= (io_bist.misr_sig == GOLDEN_SIG);
      end else if ((r_state == StDone) && !io_bist.bist_start) begin
        r_pass <= 1'b0;
      end
    end
  end

  // Moore outputs
  always_comb begin
    w_bist_mode = 1'b0;
    w_tpg_init  = 1'b0;
    w_tpg_en    = 1'b0;
    w_misr_init = 1'b0;
    w_misr_en   = 1'b0;
    w_scan_en   = 1'b0;
    w_bist_end  = 1'b0;
    case (r_state)
      StInit: begin
        w_bist_mode = 1'b1;
        w_tpg_init  = 1'b1;
        w_misr_init = 1'b1;
      end
      StShift: begin
        w_bist_mode = 1'b1;
        w_scan_en   = 1'b1;
        w_tpg_en    = 1'b1;
        w_misr_en   = !r_first;
      end
      StCapture: begin
        w_bist_mode = 1'b1;
      end
      StUnload: begin
        w_bist_mode = 1'b1;
        w_scan_en   = 1'b1;
        w_misr_en   = 1'b1;
      end
      StDone: begin
        w_bist_end  = 1'b1;
      end
      default: begin
      end
    endcase
  end

  assign io_bist.bist_mode  = w_bist_mode;
  assign io_bist.tpg_init   = w_tpg_init;
  assign io_bist.tpg_en     = w_tpg_en;
  assign io_bist.misr_init  = w_misr_init;
  assign io_bist.misr_en    = w_misr_en;
  assign io_bist.scan_en    = w_scan_en;
  assign io_bist.busy       = w_busy;
  assign io_bist.bist_end   = w_bist_end;
  assign io_bist.pass_nfail = r_pass && (r_state == StDone);

endmodule
